// File: rtl/dcsk_tx_frame_ctrl.sv
// DCSK transmit frame sequencer: preamble + MSB-first payload, one bit per
// symbol period, with a fixed spread factor per frame and a guard gap.
module dcsk_tx_frame_ctrl #(
    parameter int PAYLOAD_BYTES = 4,
    parameter int PREAMBLE_BITS = 8,
    parameter int GUARD_CYCLES  = 16
) (
    input  logic       Clk,
    input  logic       N_Rst,
    input  logic       Tx_Req,
    input  logic [1:0] Sf_Sel_Cfg,
    input  logic [7:0] Byte_In,
    input  logic       Byte_Valid,
    output logic       Byte_Ready,
    output logic       Mod_Bit,
    output logic       Mod_Valid,
    output logic [1:0] Spread_Factor_Sel,
    output logic       Busy,
    output logic       Frame_Done,
    output logic       Frame_Abort
);

    localparam int TOTAL = PREAMBLE_BITS + 8 * PAYLOAD_BYTES;
    localparam int BW    = $clog2(TOTAL + 1);
    localparam int YW    = $clog2(PAYLOAD_BYTES + 1);
    localparam int GW    = $clog2(GUARD_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, GUARD} state_t;

    state_t          state;
    logic [6:0]      cnt;
    logic [BW-1:0]   bit_idx;
    logic [YW-1:0]   fetched;
    logic [GW-1:0]   gcnt;
    logic [7:0]      buf_q;
    logic            buf_full;
    logic [6:0]      shreg;

    logic [6:0] per_last;
    logic       active;
    logic       period_end;
    logic       near_end;
    logic       last_bit;
    logic       drain;
    logic       xfer;

    // Bit index whose final cycle moves the buffer into the shift register.
    function automatic logic is_drain(input logic [BW-1:0] idx);
        int b;
        b = int'(idx);
        if (b == PREAMBLE_BITS - 1) return 1'b1;
        if (b < PREAMBLE_BITS || b >= TOTAL - 8) return 1'b0;
        return ((b - PREAMBLE_BITS) % 8) == 7;
    endfunction

    assign per_last   = 7'((8'd16 << Spread_Factor_Sel) - 8'd1);
    assign active     = (state == PREAMBLE) || (state == PAYLOAD);
    assign period_end = (cnt == per_last);
    assign near_end   = (cnt == per_last - 7'd1);
    assign last_bit   = (bit_idx == BW'(TOTAL - 1));
    assign drain      = is_drain(bit_idx);
    assign Busy       = (state != IDLE);
    assign Byte_Ready = active && !buf_full
                        && (fetched < YW'(PAYLOAD_BYTES));
    assign xfer       = Byte_Valid && Byte_Ready;

    always_ff @(posedge Clk or negedge N_Rst) begin
        if (!N_Rst) begin
            state             <= IDLE;
            cnt               <= '0;
            bit_idx           <= '0;
            fetched           <= '0;
            gcnt              <= '0;
            buf_q             <= '0;
            buf_full          <= 1'b0;
            shreg             <= '0;
            Mod_Bit           <= 1'b0;
            Mod_Valid         <= 1'b0;
            Spread_Factor_Sel <= 2'b00;
            Frame_Done        <= 1'b0;
            Frame_Abort       <= 1'b0;
        end else begin
            Frame_Done  <= 1'b0;
            Frame_Abort <= 1'b0;
            Mod_Valid   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Tx_Req) begin
                        state             <= PREAMBLE;
                        Spread_Factor_Sel <= Sf_Sel_Cfg;
                        cnt               <= '0;
                        bit_idx           <= '0;
                        fetched           <= '0;
                        buf_full          <= 1'b0;
                        Mod_Valid         <= 1'b1;
                        Mod_Bit           <= 1'b1;
                    end
                end
                PREAMBLE, PAYLOAD: begin
                    if (xfer) begin
                        buf_q    <= Byte_In;
                        buf_full <= 1'b1;
                        fetched  <= fetched + YW'(1);
                    end
                    // Pulses are raised one cycle early so they land on
                    // the final cycle of the bit period.
                    if (near_end && last_bit)
                        Frame_Done <= 1'b1;
                    if (near_end && drain && !(buf_full || xfer))
                        Frame_Abort <= 1'b1;
                    if (!period_end) begin
                        cnt <= cnt + 7'd1;
                    end else if (last_bit || (drain && !buf_full)) begin
                        state    <= GUARD;
                        gcnt     <= '0;
                        Mod_Bit  <= 1'b0;
                        buf_full <= 1'b0;
                    end else begin
                        cnt       <= '0;
                        Mod_Valid <= 1'b1;
                        bit_idx   <= bit_idx + BW'(1);
                        if (drain) begin
                            state    <= PAYLOAD;
                            shreg    <= buf_q[6:0];
                            Mod_Bit  <= buf_q[7];
                            buf_full <= 1'b0;
                        end else if (state == PREAMBLE) begin
                            Mod_Bit <= ~Mod_Bit;
                        end else begin
                            Mod_Bit <= shreg[6];
                            shreg   <= {shreg[5:0], 1'b0};
                        end
                    end
                end
                GUARD: begin
                    Mod_Bit <= 1'b0;
                    if (gcnt == GW'(GUARD_CYCLES - 1))
                        state <= IDLE;
                    else
                        gcnt <= gcnt + GW'(1);
                end
            endcase
        end
    end

endmodule
